// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch constants and fetch-state encoding
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - two-entry {inst, pc} buffer with push/pop/flush
module inst_fetch_fifo #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    assign head_data = mem[rd_ptr];
    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);

    // Flush only rewinds the pointers; stale data stays hidden behind empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= RESET_DATA;
            mem[1] <= RESET_DATA;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch PC, 2-deep fetch buffer, redirect (INST_FETCH_MISALIGN_TRAP_EN adds misalign trap)
module inst_fetch #(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(riscv_pkg::RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    ,
    output logic            trap_misalign
`endif
);

    import riscv_pkg::*;

    logic [XLEN-1:0]   pc;
    fetch_state_t      state;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              capture;
    logic [2*XLEN-1:0] head_data;

    assign imem_pc   = pc;
    assign out_valid = !fifo_empty;

    // A redirect flushes anyway, so a simultaneous handshake is ignored.
    assign pop     = out_valid && out_ready && !redirect_valid;
    assign capture = !redirect_valid && (state == ST_FETCH) && (!fifo_full || pop);

    inst_fetch_fifo #(
        .WIDTH      (2 * XLEN),
        .RESET_DATA ({XLEN'(NOP_INST), RESET_PC})
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (capture),
        .push_data  ({imem_inst, pc}),
        .pop        (pop),
        .flush      (redirect_valid),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign out_inst = head_data[2*XLEN-1:XLEN];
    assign out_pc   = head_data[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= ST_FETCH;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            trap_misalign <= 1'b0;
`endif
        end else if (redirect_valid) begin
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            // Misaligned target halts with the PC frozen until an aligned redirect.
            if (redirect_pc[1:0] != 2'b00) begin
                state         <= ST_HALT;
                trap_misalign <= 1'b1;
            end else begin
                pc            <= redirect_pc;
                state         <= ST_FETCH;
                trap_misalign <= 1'b0;
            end
`else
            pc <= redirect_pc & ~XLEN'(3);
`endif
        end else if (capture) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - queue-model self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    logic        trap_misalign;
`endif

    inst_fetch #(
        .XLEN           (32),
        .RESET_PC       (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        ,
        .trap_misalign  (trap_misalign)
`endif
    );

    // Instruction memory: word i holds the value i.
    assign imem_inst = {2'b00, imem_pc[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;
    bit          halted;
    bit          mtrap;
    logic [31:0] log_pc[$];
    logic [31:0] log_inst[$];
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc    = 32'h0000_0000;
        halted = 1'b0;
        mtrap  = 1'b0;
    endtask

    // Clock-edge behaviour from the rules: redirect wins, else pop then capture if room.
    task automatic model_edge();
        int n;
        bit popped;
        if (!rst_n) return;
        n = q.size();
        if (redirect_valid) begin
            q.delete();
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            if (redirect_pc[1:0] != 2'b00) begin
                halted = 1'b1;
                mtrap  = 1'b1;
            end else begin
                halted = 1'b0;
                mtrap  = 1'b0;
                mpc    = redirect_pc;
            end
`else
            mpc = redirect_pc & 32'hFFFF_FFFC;
`endif
        end else begin
            popped = (n > 0) && out_ready;
            if (popped) void'(q.pop_front());
            if (!halted && (n < 2 || popped)) begin
                q.push_back('{mpc >> 2, mpc});
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic compare();
        chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
        chk("imem_pc", imem_pc, mpc);
        if (q.size() > 0) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_inst", out_inst, q[0].inst);
        end
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        chk("trap_misalign", {31'b0, trap_misalign}, {31'b0, mtrap});
`endif
        if (out_valid && out_ready) begin
            log_pc.push_back(out_pc);
            log_inst.push_back(out_inst);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'h0000_0000);
        chk("rst_out_inst", out_inst, 32'h0000_0013);
        chk("rst_imem_pc", imem_pc, 32'h0000_0000);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
        log_pc.delete();
        log_inst.delete();
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < log_pc.size()) ? log_pc[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset();

        // Streaming at one per cycle from reset.
        out_ready = 1'b1;
        repeat (6) cycle();
        chk("a_count", log_pc.size(), 32'd5);
        for (int i = 0; i < 3; i++) begin
            chk("a_pc", log_at(i), 32'(i * 4));
            chk("a_inst", (i < log_inst.size()) ? log_inst[i] : 32'hDEAD_BEEF, 32'(i));
        end

        // Mid-stream reset, then back-pressure fills the buffer.
        pulse_reset();
        out_ready = 1'b0;
        log_pc.delete();
        log_inst.delete();
        repeat (5) cycle();
        chk("b_imem_pc", imem_pc, 32'h8);
        chk("b_out_valid", {31'b0, out_valid}, 32'd1);
        chk("b_out_pc", out_pc, 32'h0);
        chk("b_out_inst", out_inst, 32'h0);
        out_ready = 1'b1;
        repeat (3) cycle();
        chk("b_count", log_pc.size(), 32'd3);
        for (int i = 0; i < 3; i++) chk("b_pc", log_at(i), 32'(i * 4));

        // Redirect while full: buffer dropped, target visible one cycle later.
        redirect(32'h100);
        chk("c_flush_valid", {31'b0, out_valid}, 32'd0);
        chk("c_imem_pc", imem_pc, 32'h100);
        cycle();
        chk("c_out_valid", {31'b0, out_valid}, 32'd1);
        chk("c_out_pc", out_pc, 32'h100);

        // PC wrap at the top of the address space.
        redirect(32'hFFFF_FFF8);
        repeat (4) cycle();
        chk("d_pc0", log_at(0), 32'hFFFF_FFF8);
        chk("d_pc1", log_at(1), 32'hFFFF_FFFC);
        chk("d_pc2", log_at(2), 32'h0000_0000);
        chk("d_inst0", (log_inst.size() > 0) ? log_inst[0] : 32'hDEAD_BEEF, 32'h3FFF_FFFE);

        // Misaligned redirect target.
        redirect(32'h102);
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        chk("e_trap", {31'b0, trap_misalign}, 32'd1);
        repeat (3) cycle();
        chk("e_halt_valid", {31'b0, out_valid}, 32'd0);
        chk("e_frozen_pc", imem_pc, 32'h8);
        redirect(32'h200);
        chk("e_trap_clr", {31'b0, trap_misalign}, 32'd0);
        cycle();
        chk("e_out_pc", out_pc, 32'h200);
`else
        cycle();
        chk("e_out_valid", {31'b0, out_valid}, 32'd1);
        chk("e_out_pc", out_pc, 32'h100);
`endif

        // Random traffic, redirects and occasional async resets.
        for (int k = 0; k < 400; k++) begin
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'h0000_0FFC;
            endcase
            cycle();
            if ($urandom_range(0, 59) == 0) pulse_reset();
        end
        redirect_valid = 1'b0;
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter XLEN, default 32: width of PC and instruction.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_pc  output  XLEN  word-aligned fetch address driven to the combinational instruction memory.
REQ-006 imem_inst  input  XLEN  instruction returned combinationally for imem_pc in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump/trap redirect request, single-cycle qualifier.
REQ-008 redirect_pc  input  XLEN  redirect target address.
REQ-009 out_valid  output  1  head of fetch buffer holds a valid instruction.
REQ-010 out_ready  input  1  decode stage accepts the head entry.
REQ-011 out_inst  output  XLEN  head instruction.
REQ-012 out_pc  output  XLEN  PC of head instruction.
REQ-013 trap_misalign  output  1  misaligned redirect target detected; present only with the macro in REQ-030.

Function
REQ-014 The block SHALL hold a fetch PC register and drive imem_pc directly from it (registered output, no combinational path from redirect_pc).
REQ-015 The block SHALL contain a 2-entry FIFO of {inst, pc} pairs.
REQ-016 Capture: in a cycle with no redirect, not trapped, and the FIFO not full or popped this cycle, {imem_inst, imem_pc} SHALL be written and the PC SHALL advance by 4.
REQ-017 Stall: when the FIFO is full and not popped, the PC SHALL hold and nothing SHALL be written.
REQ-018 Pop: out_valid && out_ready SHALL remove the head entry at the clock edge; full+pop+capture in one cycle SHALL leave the FIFO full.
REQ-019 out_valid SHALL equal FIFO non-empty; out_inst/out_pc SHALL be stable while out_valid && !out_ready.
REQ-020 Redirect: redirect_valid SHALL flush the FIFO, load the PC with redirect_pc, and suppress capture that cycle; redirect has priority over simultaneous pop and capture.
REQ-021 Redirect-to-first-valid latency SHALL be exactly 1 cycle (out_valid high in the second cycle after the redirect edge, i.e. target captured in the cycle after redirect).
REQ-022 PC increment SHALL wrap modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000) without special handling.
REQ-023 State machine: FETCH (normal capture/stall) and HALT (trap, entered only per REQ-030); without the macro only FETCH exists.

Reset
REQ-024 Assertion of rst_n low SHALL immediately set PC = RESET_PC, FIFO empty, out_valid = 0, trap_misalign = 0, state = FETCH.
REQ-025 out_inst and out_pc SHALL reset to 32'h0000_0013 (NOP) and RESET_PC respectively.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries and any pending redirect.
REQ-027 First capture SHALL occur in the first clock edge after rst_n deasserts.

Configuration
REQ-028 Macro INST_FETCH_MISALIGN_TRAP_EN selects misaligned-target handling.
REQ-029 Without the macro: redirect_pc[1:0] SHALL be forced to 2'b00 when loaded; trap_misalign port absent.
REQ-030 With the macro: redirect_pc[1:0] != 0 SHALL set trap_misalign (sticky), enter HALT, flush FIFO, and stop capture; only a later redirect with aligned target (or reset) SHALL clear the trap and return to FETCH.

Structure
REQ-031 Shared package riscv_pkg SHALL hold XLEN, RESET_PC default, NOP encoding 32'h0000_0013, and the fetch-state enum.
REQ-032 The FIFO SHALL be a sub-module inst_fetch_fifo (depth 2, width 2*XLEN, push/pop/flush, full/empty).

Verification
REQ-033 Reset release, out_ready=1, IMEM word i = i -> out_pc 0,4,8,... with out_inst 0,1,2,... one per cycle after first fill.
REQ-034 out_ready=0 for 5 cycles -> FIFO fills with PC 0,4; imem_pc holds 8; out held stable; release -> 8 delivered next, no loss/duplication.
REQ-035 redirect_valid with redirect_pc=0x100 while FIFO full and out_ready=1 -> buffered entries dropped, next out_pc = 0x100 exactly 1 cycle later.
REQ-036 PC loaded 0xFFFF_FFF8 via redirect -> out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-037 With macro, redirect_pc=0x102 -> trap_misalign=1, out_valid=0, imem_pc frozen; redirect_pc=0x200 -> trap cleared, out_pc 0x200 follows. Without macro, same stimulus -> out_pc 0x100.
REQ-038 rst_n pulsed low mid-stream -> out_valid drops asynchronously, fetch restarts at RESET_PC.
